// File: rtl/picomips_core.sv
// picoMips accumulator core: FETCH/EXEC sequencer, register file, ALU, branches, valid/ready I/O.
// Optional signed fractional multiply is enabled by defining PICOMIPS_MUL_EN.
module picomips_core #(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 4,
    parameter int PROG_DEPTH = 32,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [PC_W-1:0]   instr_addr_o,
    input  logic [DATA_W+3:0] instr_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_OUT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LDR  = 4'd2;
    localparam logic [3:0] OP_STR  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_ADDR = 4'd5;
    localparam logic [3:0] OP_SUBR = 4'd6;
    localparam logic [3:0] OP_MULI = 4'd7;
    localparam logic [3:0] OP_MULR = 4'd8;
    localparam logic [3:0] OP_IN   = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_BZ   = 4'd12;
    localparam logic [3:0] OP_BN   = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];

    logic [3:0]          opcode_s;
    logic [DATA_W-1:0]   operand_s;
    logic [DATA_W-1:0]   reg_rd_s;
    logic                reg_we_s;
    logic                in_ready_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     tgt_raw_s;
    logic [PC_W-1:0]     tgt_s;

    assign opcode_s  = instr_i[DATA_W+3:DATA_W];
    assign operand_s = instr_i[DATA_W-1:0];

    // Out-of-range register indices never match, so they read as zero.
    always_comb begin
        reg_rd_s = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_rd_s = reg_rd_s | ((operand_s == DATA_W'(i)) ? regs_q[i] : '0);
        end
    end

    assign pc_inc_s  = (pc_q == PC_W'(PROG_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
    assign tgt_raw_s = operand_s[PC_W-1:0];
    assign tgt_s     = ({1'b0, tgt_raw_s} >= (PC_W+1)'(PROG_DEPTH))
                       ? tgt_raw_s - PC_W'(PROG_DEPTH) : tgt_raw_s;

`ifdef PICOMIPS_MUL_EN
    logic [DATA_W-1:0]          mul_b_s;
    logic signed [2*DATA_W-1:0] mul_prod_s;
    logic [DATA_W-1:0]          mul_res_s;

    assign mul_b_s    = (opcode_s == OP_MULR) ? reg_rd_s : operand_s;
    // Q1.(DATA_W-1) product: drop DATA_W-1 fraction bits, keep the low word.
    assign mul_prod_s = $signed(acc_q) * $signed(mul_b_s);
    assign mul_res_s  = DATA_W'(mul_prod_s >>> (DATA_W - 1));
`endif

    // Sequencer next-state and datapath decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        reg_we_s    = 1'b0;
        in_ready_s  = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc_s;
                case (opcode_s)
                    OP_LDI:  acc_d = operand_s;
                    OP_LDR:  acc_d = reg_rd_s;
                    OP_STR:  reg_we_s = 1'b1;
                    OP_ADDI: acc_d = acc_q + operand_s;
                    OP_ADDR: acc_d = acc_q + reg_rd_s;
                    OP_SUBR: acc_d = acc_q - reg_rd_s;
                    OP_MULI, OP_MULR: begin
`ifdef PICOMIPS_MUL_EN
                        acc_d = mul_res_s;
`else
                        acc_d = acc_q;
`endif
                    end
                    OP_IN: begin
                        in_ready_s = 1'b1;
                        if (in_valid_i) begin
                            acc_d = in_data_i;
                        end else begin
                            state_d = S_EXEC;
                            pc_d    = pc_q;
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_WAIT_OUT;
                        pc_d        = pc_q;
                    end
                    OP_JMP: pc_d = tgt_s;
                    OP_BZ: begin
                        if (acc_q == '0) pc_d = tgt_s;
                        else             pc_d = pc_inc_s;
                    end
                    OP_BN: begin
                        if (acc_q[DATA_W-1]) pc_d = tgt_s;
                        else                 pc_d = pc_inc_s;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: acc_d = acc_q;
                endcase
            end
            S_WAIT_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_inc_s;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WAIT_OUT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Sequencer, accumulator and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Register file; a write to an index beyond REG_COUNT matches nothing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we_s) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (operand_s == DATA_W'(i)) regs_q[i] <= acc_q;
            end
        end
    end

    assign instr_addr_o = pc_q;
    assign in_ready_o   = in_ready_s;
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign acc_o        = acc_q;
    assign halted_o     = (state_q == S_HALT);

endmodule

// File: tb/tb_picomips_core.sv
// Bench for picomips_core: directed program table, I/O handshake sequences and random
// programs checked against an instruction-level reference model.
module tb_picomips_core;

    localparam int DW = 8;
    localparam int NREG = 4;
    localparam int DEPTH = 32;
`ifdef PICOMIPS_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    instr_addr;
    logic [11:0]   instr;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    acc;
    logic          halted;

    logic [11:0]   rom [DEPTH];
    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [7:0]    dut_outs[$];
    logic [4:0]    addr_trace[$];
    int            model_outs[$];

    picomips_core #(.DATA_W(DW), .REG_COUNT(NREG), .PROG_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(rst), .instr_addr_o(instr_addr), .instr_i(instr),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .acc_o(acc), .halted_o(halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read program ROM
    always @(posedge clk) instr <= rom[instr_addr];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Instruction-level model: returns final acc and the cycle index at which Halted rises.
    function automatic void model_run(input int inval, output int acc_m, output int cyc_m);
        int pc, a, opc, opr, nxt, cyc;
        int r[NREG];
        pc = 0; a = 0; cyc = 0; cyc_m = -1;
        for (int i = 0; i < NREG; i++) r[i] = 0;
        model_outs.delete();
        for (int s = 0; s < 1000; s++) begin
            opc = int'(rom[pc][11:8]);
            opr = int'(rom[pc][7:0]);
            cyc += 2;
            nxt = (pc + 1) % DEPTH;
            case (opc)
                1: a = opr;
                2: a = (opr < NREG) ? r[opr] : 0;
                3: if (opr < NREG) r[opr] = a;
                4: a = (a + opr) % 256;
                5: a = (a + ((opr < NREG) ? r[opr] : 0)) % 256;
                6: a = (a + 256 - ((opr < NREG) ? r[opr] : 0)) % 256;
                7, 8: if (MUL_ON) a = ((sx(a) * sx((opc == 8) ? ((opr < NREG) ? r[opr] : 0) : opr)) >>> 7) & 255;
                9: a = inval;
                10: begin model_outs.push_back(a); cyc += 1; end
                11: nxt = opr % DEPTH;
                12: if (a == 0) nxt = opr % DEPTH;
                13: if (a >= 128) nxt = opr % DEPTH;
                14: begin acc_m = a; cyc_m = cyc; return; end
                default: ;
            endcase
            pc = nxt;
        end
        acc_m = a;
    endfunction

    // Reset, then run until Halted (bounded), collecting outputs and the fetch trace.
    task automatic run_prog(input int budget, output logic [7:0] acc_h, output int cyc_h, output bit to);
        dut_outs.delete();
        addr_trace.delete();
        to = 1'b1; cyc_h = -1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            addr_trace.push_back(instr_addr);
            if (out_valid && out_ready) dut_outs.push_back(out_data);
            if (halted) begin cyc_h = c; to = 1'b0; break; end
        end
        acc_h = acc;
    endtask

    typedef struct {
        logic [0:7][11:0] prog;
        int exp_acc;
        int exp_cyc;
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] acc_h;
    int         cyc_h, rdy, xfer, cnt, macc, mcyc;
    bit         to;
    logic [3:0] opc;
    logic [7:0] opr;
    logic [7:0] rin;

    initial begin
        tbl[0] = '{prog: {12'h105, 12'h403, 12'h301, 12'h601, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 0, exp_cyc: 10};
        tbl[1] = '{prog: {12'h17F, 12'h401, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 128, exp_cyc: 6};
        tbl[2] = '{prog: {12'h140, 12'h740, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: MUL_ON ? 32 : 64, exp_cyc: 6};
        tbl[3] = '{prog: {12'h180, 12'h780, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 128, exp_cyc: 6};
        tbl[4] = '{prog: {12'h103, 12'h4FF, 12'hC04, 12'hB01, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 0, exp_cyc: 20};
        tbl[5] = '{prog: {12'h180, 12'hD03, 12'h101, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 128, exp_cyc: 6};
        tbl[6] = '{prog: {12'h109, 12'h305, 12'h101, 12'h205, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 0, exp_cyc: 10};
        tbl[7] = '{prog: {12'h107, 12'h302, 12'h100, 12'h202, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 7, exp_cyc: 10};
        tbl[8] = '{prog: {12'h140, 12'h300, 12'h1C0, 12'h800, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: MUL_ON ? 224 : 192, exp_cyc: 10};
        tbl[9] = '{prog: {12'h104, 12'hF00, 12'h000, 12'hE00, 12'hE00, 12'hE00, 12'hE00, 12'hE00}, exp_acc: 4, exp_cyc: 8};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) rom[a] = 12'h000;
        @(posedge clk); #1;
        check("reset_acc", int'(acc), 0);
        check("reset_addr", int'(instr_addr), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_halted", int'(halted), 0);

        for (int i = 0; i < 10; i++) begin
            for (int a = 0; a < DEPTH; a++) rom[a] = (a < 8) ? tbl[i].prog[a] : 12'hE00;
            run_prog(100, acc_h, cyc_h, to);
            check($sformatf("vec%0d_timeout", i), int'(to), 0);
            check($sformatf("vec%0d_acc", i), int'(acc_h), tbl[i].exp_acc);
            check($sformatf("vec%0d_cycles", i), cyc_h, tbl[i].exp_cyc);
        end

        // PC wraps from 31 to 0; Halted and Acc stay frozen afterwards.
        for (int a = 0; a < DEPTH; a++) rom[a] = 12'h000;
        rom[0] = 12'hC1E; rom[1] = 12'hE00; rom[30] = 12'h101;
        run_prog(100, acc_h, cyc_h, to);
        check("wrap_cycles", cyc_h, 10);
        check("wrap_addr31", (addr_trace.size() > 6) ? int'(addr_trace[4]) : -1, 31);
        check("wrap_addr0", (addr_trace.size() > 6) ? int'(addr_trace[6]) : -1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_frozen", int'(halted), 1);
        check("halt_acc_frozen", int'(acc), 1);

        // IN handshake: InValid held low for 4 ready cycles, data offered on the 5th.
        for (int a = 0; a < DEPTH; a++) rom[a] = 12'h000;
        rom[0] = 12'h900; rom[1] = 12'hE00;
        in_valid = 1'b0;
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        rdy = 0; xfer = 0; cyc_h = -1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (halted) begin cyc_h = c; break; end
            if (in_ready) begin
                rdy++;
                if (rdy == 5) begin in_valid = 1'b1; in_data = 8'h2A; end
            end
            if (in_valid && in_ready) xfer++;
        end
        in_valid = 1'b0;
        check("in_ready_cycles", rdy, 5);
        check("in_transfers", xfer, 1);
        check("in_acc", int'(acc), 42);
        check("in_halt_cycle", cyc_h, 8);

        // OUT backpressure, then reset while waiting.
        rom[0] = 12'h15A; rom[1] = 12'hA00; rom[2] = 12'hE00;
        out_ready = 1'b0;
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c >= 4 && out_valid && out_data == 8'h5A) cnt++;
        end
        check("out_held_cycles", cnt, 5);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        check("out_reset_valid", int'(out_valid), 0);
        check("out_reset_addr", int'(instr_addr), 0);
        out_ready = 1'b1;
        run_prog(100, acc_h, cyc_h, to);
        check("out_cycles", cyc_h, 7);
        check("out_count", dut_outs.size(), 1);
        check("out_value", (dut_outs.size() > 0) ? int'(dut_outs[0]) : -1, 90);
        check("out_data_hold", int'(out_data), 90);
        check("out_valid_after", int'(out_valid), 0);

        // Random forward-branching programs followed by a register dump.
        in_valid = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int a = 0; a < DEPTH; a++) rom[a] = 12'h000;
            for (int a = 0; a < 16; a++) begin
                opc = 4'($urandom_range(0, 15));
                opr = 8'($urandom);
                if (opc == 4'd14) opc = 4'd4;
                if (opc == 4'd2 || opc == 4'd3 || opc == 4'd5 || opc == 4'd6 || opc == 4'd8)
                    opr = 8'($urandom_range(0, 7));
                if (opc >= 4'd11 && opc <= 4'd13) opr = 8'($urandom_range(16, a + 1));
                rom[a] = {opc, opr};
            end
            for (int k = 0; k < NREG; k++) begin
                rom[16 + 2 * k] = {4'h2, 8'(k)};
                rom[17 + 2 * k] = 12'hA00;
            end
            rom[24] = 12'hE00;
            rin = 8'($urandom);
            in_data = rin;
            model_run(int'(rin), macc, mcyc);
            run_prog(300, acc_h, cyc_h, to);
            check($sformatf("rnd%0d_timeout", p), int'(to), 0);
            check($sformatf("rnd%0d_acc", p), int'(acc_h), macc);
            check($sformatf("rnd%0d_cycles", p), cyc_h, mcyc);
            check($sformatf("rnd%0d_out_count", p), dut_outs.size(), model_outs.size());
            for (int k = 0; k < model_outs.size() && k < dut_outs.size(); k++)
                check($sformatf("rnd%0d_out%0d", p, k), int'(dut_outs[k]), model_outs[k]);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/picomips_core.md
# picomips_core

Parametrised second-generation picoMips accumulator core: a two-state fetch/execute sequencer, register file, ALU with optional signed fractional multiply, conditional branching and valid/ready I/O ports. It replaces the fixed 8-bit, 2-register, switch/LED core. It sits between an external synchronous-read program ROM and the board-level I/O glue.

## Interface
Parameters:
- DATA_W, 8: accumulator, register, immediate and I/O width; minimum 4.
- REG_COUNT, 4: general registers, 1..2^DATA_W.
- PROG_DEPTH, 32: program words, 2..2^DATA_W.
- PC_W, $clog2(PROG_DEPTH): program counter width.

Ports:
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- InstrAddr  out  PC_W  program ROM address.
- Instr  in  4+DATA_W  ROM data, valid one cycle after InstrAddr; {opcode[3:0], operand[DATA_W-1:0]}.
- InData  in  DATA_W  input word.
- InValid  in  1  InData valid.
- InReady  out  1  core accepts InData this cycle.
- OutData  out  DATA_W  output word.
- OutValid  out  1  OutData valid.
- OutReady  in  1  sink accepts OutData.
- Acc  out  DATA_W  accumulator, signed.
- Halted  out  1  core stopped.

## Operation
- States: FETCH, EXEC, WAIT_OUT, HALT. FETCH drives InstrAddr=PC, then EXEC. EXEC decodes Instr and retires.
- Opcodes (op = operand; R[op] = register op):
  - 0 NOP
  - 1 LDI: Acc=op
  - 2 LDR: Acc=R[op]
  - 3 STR: R[op]=Acc
  - 4 ADDI: Acc+=op
  - 5 ADDR: Acc+=R[op]
  - 6 SUBR: Acc-=R[op]
  - 7 MULI: Acc=(Acc*op)>>>(DATA_W-1)
  - 8 MULR: as MULI with R[op]
  - 9 IN
  - 10 OUT
  - 11 JMP: PC=op
  - 12 BZ: PC=op if Acc==0
  - 13 BN: PC=op if Acc[DATA_W-1]
  - 14 HALT
  - 15 reserved, executes as NOP.
- Add/sub wrap modulo 2^DATA_W; no flags. Multiply is full 2*DATA_W signed product, arithmetic shift right DATA_W-1, truncated to DATA_W (Q1.(DATA_W-1) fractional).
- Branch/jump target uses op[PC_W-1:0]; targets >= PROG_DEPTH wrap modulo PROG_DEPTH. Sequential PC increments and wraps PROG_DEPTH-1 -> 0.
- Register index >= REG_COUNT: STR ignored, reads return 0.
- IN: stays in EXEC with InReady=1 until InValid; on InValid&&InReady Acc=InData, retire. InReady is 0 in every other state/opcode.
- OUT: OutData<=Acc, OutValid<=1, enter WAIT_OUT; on OutValid&&OutReady clear OutValid, go FETCH with PC+1. OutData holds its last value after the transfer.
- HALT: Halted=1, sequencer frozen until Reset.

## Timing
- Reset: PC=0, Acc=0, all R=0, OutData=0, OutValid=0, InReady=0, Halted=0, state FETCH; InstrAddr=0 in the first cycle after Reset falls.
- Non-I/O instruction: exactly 2 cycles (FETCH, EXEC). Acc/R/PC update at the end of EXEC.
- IN with InValid already high at EXEC: 2 cycles. Each stalled cycle adds 1.
- OUT: OutValid rises at the end of EXEC; minimum 3 cycles when OutReady is held high.
- STR then LDR of the same register: read returns the new value (no hazard; 2-cycle issue).
- Reset mid-WAIT_OUT or mid-IN: the pending transfer is dropped; OutValid is 0 the next cycle.
- Reset wins over every simultaneous event.

## Configuration
- PICOMIPS_MUL_EN defined: opcodes 7/8 multiply as above; a single-cycle DATA_W x DATA_W signed multiplier is instantiated.
- Undefined: no multiplier is instantiated; opcodes 7/8 execute as NOP (2 cycles, Acc unchanged).

## Test plan
Default parameters apply unless noted.
- Reset and straight-line: LDI 5; ADDI 3; STR 1; SUBR 1; HALT -> Acc 8 then 0; Halted=1 at cycle 10; PC frozen.
- Wrap: LDI 127; ADDI 1 -> Acc=-128 (0x80); a program running past address 31 fetches address 0.
- Multiply, with PICOMIPS_MUL_EN: LDI 64 (0.5); MULI 64 -> Acc=32. LDI -128; MULI -128 -> Acc=-128 (truncation). Without the macro, Acc stays 64 / -128.
- Branch loop: LDI 3; loop: ADDI -1; BZ end; JMP loop -> BZ taken only when Acc=0; total cycle count 20 to HALT.
- IN handshake: IN with InValid low for 4 cycles, then InData=0x2A -> InReady high for 5 cycles, Acc=42, a single transfer.
- OUT backpressure plus reset: OUT with OutReady low -> OutValid held and OutData stable. Asserting Reset in WAIT_OUT -> OutValid=0, PC=0, next cycle.
